// File: rtl/regfile_sb.sv
// General-purpose register file with N combinational read ports, optional
// writeback bypass and a per-register in-flight write scoreboard.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int CNT_WIDTH  = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_wen,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_i,
  input  logic [DATA_WIDTH-1:0]        rd_data_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rs_data_o,
  output logic [NUM_RD-1:0]            rs_busy_o,
  input  logic                         issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]        issue_addr_i,
  output logic                         issue_ready_o,
  input  logic                         flush_i,
  output logic                         any_busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt  [DEPTH];

  logic             wb_dec;
  logic             issue_fire;
  logic [DEPTH-1:0] inc_vec;
  logic [DEPTH-1:0] dec_vec;

  // cnt[0] is never incremented, so wb_dec already excludes index 0.
  assign wb_dec = rd_wen && (cnt[rd_addr_i] != '0);

  assign issue_ready_o = !flush_i &&
                         ((issue_addr_i == '0) ||
                          (cnt[issue_addr_i] != CNT_MAX) ||
                          (wb_dec && (rd_addr_i == issue_addr_i)));

  assign issue_fire = issue_valid_i && issue_ready_o && (issue_addr_i != '0);

  // NOTE: every always_comb output gets a default before the loop so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < DEPTH; r++) begin
      inc_vec[r] = issue_fire && (issue_addr_i == ADDR_WIDTH'(r));
      dec_vec[r] = wb_dec && (rd_addr_i == ADDR_WIDTH'(r));
    end
  end

  always_comb begin
    any_busy_o = 1'b0;
    for (int r = 0; r < DEPTH; r++) any_busy_o = any_busy_o | (cnt[r] != '0);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the data array is reset too, since reads after reset must return 0
  // for every index; this keeps the storage in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (rd_wen && (rd_addr_i != '0)) regs[rd_addr_i] <= rd_data_i;
      for (int r = 0; r < DEPTH; r++) begin
        if (flush_i) begin
          cnt[r] <= '0;
        end else begin
          case ({inc_vec[r], dec_vec[r]})
            2'b10:   cnt[r] <= cnt[r] + CNT_ONE;
            2'b01:   cnt[r] <= cnt[r] - CNT_ONE;
            default: cnt[r] <= cnt[r];
          endcase
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] idx;
    logic                  bypass_hit;

    assign idx        = rs_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign bypass_hit = BYPASS && rd_wen && (rd_addr_i == idx);

    assign rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] =
        (idx == '0) ? '0 : (bypass_hit ? rd_data_i : regs[idx]);

    // With bypass, the last outstanding write retiring now already satisfies the reader.
    assign rs_busy_o[k] = (idx != '0) && (cnt[idx] != '0) &&
                          !(bypass_hit && (cnt[idx] == CNT_ONE));
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassed and a non-bypassed instance share
// stimulus; expected outputs come from a hand-computed vector table.
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, rd_wen, issue_valid, flush;
  logic [AW-1:0]  rd_addr, issue_addr;
  logic [DW-1:0]  rd_data;
  logic [NR*AW-1:0] rs_addr;
  logic [NR*DW-1:0] rs_data, rs_data_nb;
  logic [NR-1:0]  rs_busy, rs_busy_nb;
  logic           ready, ready_nb, any, any_nb;

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .CNT_WIDTH(CW),
               .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rd_wen(rd_wen), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
    .rs_addr_i(rs_addr), .rs_data_o(rs_data), .rs_busy_o(rs_busy),
    .issue_valid_i(issue_valid), .issue_addr_i(issue_addr), .issue_ready_o(ready),
    .flush_i(flush), .any_busy_o(any));

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .CNT_WIDTH(CW),
               .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rd_wen(rd_wen), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
    .rs_addr_i(rs_addr), .rs_data_o(rs_data_nb), .rs_busy_o(rs_busy_nb),
    .issue_valid_i(issue_valid), .issue_addr_i(issue_addr), .issue_ready_o(ready_nb),
    .flush_i(flush), .any_busy_o(any_nb));

  typedef struct {
    bit          chk;
    bit          rst;
    bit          wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    bit          iv;
    logic [4:0]  iaddr;
    bit          flush;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    bit          ready;
    bit          any;
    logic [31:0] d0_nb;
    logic [1:0]  busy_nb;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit chk, input bit r, input bit wen, input logic [4:0] waddr,
                     input logic [31:0] wdata, input logic [4:0] rs0, input logic [4:0] rs1,
                     input bit iv, input logic [4:0] iaddr, input bit fl,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] busy,
                     input bit rdy, input bit anyb, input logic [31:0] d0_nb,
                     input logic [1:0] busy_nb);
    vec_t v;
    v.chk = chk; v.rst = r; v.wen = wen; v.waddr = waddr; v.wdata = wdata;
    v.rs0 = rs0; v.rs1 = rs1; v.iv = iv; v.iaddr = iaddr; v.flush = fl;
    v.d0 = d0; v.d1 = d1; v.busy = busy; v.ready = rdy; v.any = anyb;
    v.d0_nb = d0_nb; v.busy_nb = busy_nb;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus, compare on the falling edge, then commit.
  task automatic apply(input int i, input vec_t v);
    rst = v.rst; rd_wen = v.wen; rd_addr = v.waddr; rd_data = v.wdata;
    rs_addr = {v.rs1, v.rs0}; issue_valid = v.iv; issue_addr = v.iaddr; flush = v.flush;
    @(negedge clk);
    if (v.chk) begin
      check($sformatf("row%0d d0", i), 64'(rs_data[31:0]), 64'(v.d0));
      check($sformatf("row%0d d1", i), 64'(rs_data[63:32]), 64'(v.d1));
      check($sformatf("row%0d busy", i), 64'(rs_busy), 64'(v.busy));
      check($sformatf("row%0d ready", i), 64'(ready), 64'(v.ready));
      check($sformatf("row%0d ready_nb", i), 64'(ready_nb), 64'(v.ready));
      check($sformatf("row%0d any", i), 64'(any), 64'(v.any));
      check($sformatf("row%0d any_nb", i), 64'(any_nb), 64'(v.any));
      check($sformatf("row%0d d0_nb", i), 64'(rs_data_nb[31:0]), 64'(v.d0_nb));
      check($sformatf("row%0d busy_nb", i), 64'(rs_busy_nb), 64'(v.busy_nb));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rd_wen = 1'b0; rd_addr = '0; rd_data = '0; rs_addr = '0;
    issue_valid = 1'b0; issue_addr = '0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Post-reset sweep of every index on both ports.
    for (int i = 0; i < 32; i++) begin
      rs_addr = {5'(31 - i), 5'(i)};
      issue_addr = 5'(i);
      @(negedge clk);
      check($sformatf("reset data x%0d", i), rs_data, 64'h0);
      check($sformatf("reset data_nb x%0d", i), rs_data_nb, 64'h0);
      check($sformatf("reset flags x%0d", i),
            64'({rs_busy, rs_busy_nb, any, any_nb, ready, ready_nb}), 64'b00_00_0_0_1_1);
      @(posedge clk);
      #1;
    end

    //  chk rst wen waddr   wdata          rs0    rs1    iv iaddr  fl  d0             d1             busy   rdy any d0_nb          busy_nb
    add(1, 0, 1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  0, 5'd0,  0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 0, 32'h0,        2'b00);
    add(1, 0, 0, 5'd0,  32'h0,        5'd5,  5'd0,  0, 5'd0,  0, 32'hDEADBEEF, 32'h0,        2'b00, 1, 0, 32'hDEADBEEF, 2'b00);
    add(1, 0, 1, 5'd0,  32'h12345678, 5'd0,  5'd0,  1, 5'd0,  0, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        2'b00);
    add(1, 0, 0, 5'd0,  32'h0,        5'd0,  5'd5,  0, 5'd0,  0, 32'h0,        32'hDEADBEEF, 2'b00, 1, 0, 32'h0,        2'b00);
    // x3 saturates at three outstanding writes, then drains.
    add(1, 0, 0, 5'd0,  32'h0,        5'd3,  5'd0,  1, 5'd3,  0, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        2'b00);
    add(1, 0, 0, 5'd0,  32'h0,        5'd3,  5'd0,  1, 5'd3,  0, 32'h0,        32'h0,        2'b01, 1, 1, 32'h0,        2'b01);
    add(1, 0, 0, 5'd0,  32'h0,        5'd3,  5'd0,  1, 5'd3,  0, 32'h0,        32'h0,        2'b01, 1, 1, 32'h0,        2'b01);
    add(1, 0, 0, 5'd0,  32'h0,        5'd3,  5'd0,  1, 5'd3,  0, 32'h0,        32'h0,        2'b01, 0, 1, 32'h0,        2'b01);
    add(1, 0, 1, 5'd3,  32'h33,       5'd3,  5'd0,  1, 5'd3,  0, 32'h33,       32'h0,        2'b01, 1, 1, 32'h0,        2'b01);
    add(1, 0, 1, 5'd3,  32'h34,       5'd3,  5'd3,  0, 5'd3,  0, 32'h34,       32'h34,       2'b11, 1, 1, 32'h33,       2'b11);
    add(1, 0, 1, 5'd3,  32'h35,       5'd3,  5'd3,  0, 5'd3,  0, 32'h35,       32'h35,       2'b11, 1, 1, 32'h34,       2'b11);
    add(1, 0, 1, 5'd3,  32'h36,       5'd3,  5'd3,  0, 5'd3,  0, 32'h36,       32'h36,       2'b00, 1, 1, 32'h35,       2'b11);
    add(1, 0, 0, 5'd0,  32'h0,        5'd3,  5'd3,  0, 5'd3,  0, 32'h36,       32'h36,       2'b00, 1, 0, 32'h36,       2'b00);
    // Flush with a refused issue to x8 and a writeback to x9.
    add(1, 0, 0, 5'd0,  32'h0,        5'd7,  5'd0,  1, 5'd7,  0, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        2'b00);
    add(1, 0, 1, 5'd9,  32'h99,       5'd9,  5'd7,  1, 5'd8,  1, 32'h99,       32'h0,        2'b10, 0, 1, 32'h0,        2'b10);
    add(1, 0, 0, 5'd0,  32'h0,        5'd9,  5'd8,  0, 5'd8,  0, 32'h99,       32'h0,        2'b00, 1, 0, 32'h99,       2'b00);
    // Retire x9, then write x10 with nothing pending: no underflow.
    add(1, 0, 0, 5'd0,  32'h0,        5'd9,  5'd0,  1, 5'd9,  0, 32'h99,       32'h0,        2'b00, 1, 0, 32'h99,       2'b00);
    add(1, 0, 1, 5'd9,  32'h9A,       5'd9,  5'd10, 0, 5'd0,  0, 32'h9A,       32'h0,        2'b00, 1, 1, 32'h99,       2'b01);
    add(1, 0, 1, 5'd10, 32'h1010,     5'd10, 5'd9,  0, 5'd0,  0, 32'h1010,     32'h9A,       2'b00, 1, 0, 32'h0,        2'b00);
    add(1, 0, 0, 5'd0,  32'h0,        5'd10, 5'd0,  1, 5'd10, 0, 32'h1010,     32'h0,        2'b00, 1, 0, 32'h1010,     2'b00);
    add(1, 0, 1, 5'd10, 32'h2020,     5'd10, 5'd11, 1, 5'd11, 0, 32'h2020,     32'h0,        2'b00, 1, 1, 32'h1010,     2'b01);
    // Reset overrides a same-cycle issue and writeback; pending x11 is dropped.
    add(0, 1, 1, 5'd4,  32'h44,       5'd10, 5'd4,  1, 5'd4,  0, 32'h0,        32'h0,        2'b00, 0, 0, 32'h0,        2'b00);
    add(1, 0, 0, 5'd0,  32'h0,        5'd10, 5'd4,  0, 5'd4,  0, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        2'b00);

    foreach (vecs[i]) apply(i, vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
